alu_ctrl_sequencer: RTL and testbench

//  Multi-cycle control FSM that drives the ALU's 4-bit ctrl_i, shamt and operand-mux selects, and consumes its zero_o.

---
 rtl/alu_ctrl_sequencer_pkg.sv | 65 ++++++
 rtl/alu_ctrl_sequencer_alu_op_decoder.sv | 71 +++++++
 rtl/alu_ctrl_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared constants for the multi-cycle CPU control sequencer:
// ALU operation codes, MIPS opcode/funct values, FSM state encodings,
// operand-B mux selects and the latched decode record.
package alu_ctrl_sequencer_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_ORI  = 4'd8;
  localparam logic [3:0] ALU_BEQ  = 4'd9;
  localparam logic [3:0] ALU_BNE  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_BRCMP  = 3'd4;
  localparam logic [2:0] ST_MEMRD  = 3'd5;
  localparam logic [2:0] ST_MEMWR  = 3'd6;
  localparam logic [2:0] ST_WB     = 3'd7;

  // Operand-B mux selects
  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_S2 = 2'd3;

  // Decode result captured in DECODE and used by later states
  typedef struct packed {
    logic [3:0] op;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_sequencer_alu_op_decoder.sv
// Combinational instruction decoder: maps opcode/funct to the ALU
// operation code and instruction-class flags.
// Ports:
//   opcode  in  6  instr[31:26]
//   funct   in  6  instr[5:0]
//   alu_op  out 4  ALU operation code
//   is_r    out 1  R-type instruction
//   is_lw   out 1  load word
//   is_sw   out 1  store word
//   is_br   out 1  beq/bne
//   illegal out 1  opcode/funct not supported
module alu_ctrl_sequencer_alu_op_decoder
  import alu_ctrl_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       is_r,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_br,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    is_r    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_br   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SLLV: alu_op = ALU_SLLV;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:  alu_op = ALU_ADD;
      OP_SLTIU: alu_op = ALU_SLTU;
      OP_ORI:   alu_op = ALU_ORI;
      OP_LUI:   alu_op = ALU_LUI;
      OP_LW: begin
        alu_op = ALU_ADD;
        is_lw  = 1'b1;
      end
      OP_SW: begin
        alu_op = ALU_ADD;
        is_sw  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_BEQ;
        is_br  = 1'b1;
      end
      OP_BNE: begin
        alu_op = ALU_BNE;
        is_br  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle CPU control sequencer. Walks FETCH/DECODE/EXEC/BRCMP/
// MEMRD/MEMWR/WB, drives ALU control and datapath mux selects, and
// guards every memory handshake with a timeout.
// Ports:
//   clk_i, rst_i (async active-low)    clock / reset
//   instr_i[31:0]                      instruction register contents
//   mem_ack_i, zero_i                  memory ack pulse, ALU zero flag
//   mem_rd_o, mem_wr_o, iord_o         memory request / address select
//   ir_we_o, pc_we_o, pc_src_o         IR and PC update controls
//   alu_ctrl_o[3:0], alu_src_a_o,
//   alu_src_b_o[1:0], shamt_o[4:0]     ALU operation and operands
//   reg_we_o, reg_dst_o, mem_to_reg_o  register file write-back
//   illegal_o, bus_err_o               single-cycle error pulses
// All outputs decode from registered state, so asserting reset forces
// them low immediately without waiting for a clock edge.
module alu_ctrl_sequencer
  import alu_ctrl_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ack_i,
  input  logic        zero_i,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        iord_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        pc_src_o,
  output logic [3:0]  alu_ctrl_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [4:0]  shamt_o,
  output logic        reg_we_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        illegal_o,
  output logic        bus_err_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q;
  dec_t       dec_q;

  logic [3:0] dec_op;
  logic       dec_is_r, dec_is_lw, dec_is_sw, dec_is_br, dec_illegal;
  logic       in_wait, tmo;
  logic       unused_instr;

  assign unused_instr = ^instr_i[25:11];

  alu_ctrl_sequencer_alu_op_decoder u_alu_op_decoder (
    .opcode  (instr_i[31:26]),
    .funct   (instr_i[5:0]),
    .alu_op  (dec_op),
    .is_r    (dec_is_r),
    .is_lw   (dec_is_lw),
    .is_sw   (dec_is_sw),
    .is_br   (dec_is_br),
    .illegal (dec_illegal)
  );

  assign in_wait = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                   (state_q == ST_MEMWR);

  // Counter sits at the limit for one extra cycle; that cycle drops the
  // request and flags the error. An ack on the last requesting cycle
  // stops the count before it can reach the limit.
  assign tmo = in_wait && (cnt_q == TMO_LIMIT);

  always_comb begin
    state_d      = state_q;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    iord_o       = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 1'b0;
    alu_ctrl_o   = ALU_ADD;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRC_B_RT;
    shamt_o      = 5'd0;
    reg_we_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    bus_err_o    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        alu_src_b_o = SRC_B_FOUR;
        if (tmo) begin
          bus_err_o = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          mem_rd_o = 1'b1;
          if (mem_ack_i) begin
            ir_we_o = 1'b1;
            pc_we_o = 1'b1;
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        alu_src_b_o = SRC_B_IMM_S2;
        if (dec_illegal) begin
          illegal_o = 1'b1;
          state_d   = ST_FETCH;
        end else if (dec_is_br) begin
          state_d = ST_BRCMP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_ctrl_o  = dec_q.op;
        alu_src_a_o = 1'b1;
        alu_src_b_o = dec_q.is_r ? SRC_B_RT : SRC_B_IMM;
        shamt_o     = instr_i[10:6];
        if (dec_q.is_lw)      state_d = ST_MEMRD;
        else if (dec_q.is_sw) state_d = ST_MEMWR;
        else                  state_d = ST_WB;
      end
      ST_BRCMP: begin
        alu_ctrl_o  = dec_q.op;
        alu_src_a_o = 1'b1;
        pc_src_o    = 1'b1;
        pc_we_o     = zero_i;
        state_d     = ST_FETCH;
      end
      ST_MEMRD: begin
        iord_o = 1'b1;
        if (tmo) begin
          bus_err_o = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          mem_rd_o = 1'b1;
          if (mem_ack_i) state_d = ST_WB;
        end
      end
      ST_MEMWR: begin
        iord_o = 1'b1;
        if (tmo) begin
          bus_err_o = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          mem_wr_o = 1'b1;
          if (mem_ack_i) state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = dec_q.is_r;
        mem_to_reg_o = dec_q.is_lw;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      // Any cycle that is not a further ack-less wait restarts the count,
      // so each entry into a wait state begins from zero.
      if (in_wait && !mem_ack_i && !tmo) cnt_q <= cnt_q + 8'd1;
      else                               cnt_q <= 8'd0;
      if (state_q == ST_DECODE) begin
        dec_q.op    <= dec_op;
        dec_q.is_r  <= dec_is_r;
        dec_q.is_lw <= dec_is_lw;
        dec_q.is_sw <= dec_is_sw;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
module tb_alu_ctrl_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        mem_ack_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        mem_rd_o, mem_wr_o, iord_o, ir_we_o, pc_we_o, pc_src_o;
  logic [3:0]  alu_ctrl_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [4:0]  shamt_o;
  logic        reg_we_o, reg_dst_o, mem_to_reg_o, illegal_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD  = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] I_BEQ  = 32'h10220003;  // beq $1,$2,3
  localparam logic [31:0] I_BNE  = 32'h14220003;  // bne $1,$2,3
  localparam logic [31:0] I_LW   = 32'h8C230004;  // lw $3,4($1)
  localparam logic [31:0] I_SW   = 32'hAC230004;  // sw $3,4($1)
  localparam logic [31:0] I_SLL  = 32'h00021940;  // sll $3,$2,5
  localparam logic [31:0] I_BADO = 32'hFC000000;  // opcode 0x3F
  localparam logic [31:0] I_BADF = 32'h0000003F;  // R-type funct 0x3F

  always #5 clk_i = ~clk_i;

  alu_ctrl_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .mem_ack_i    (mem_ack_i),
    .zero_i       (zero_i),
    .mem_rd_o     (mem_rd_o),
    .mem_wr_o     (mem_wr_o),
    .iord_o       (iord_o),
    .ir_we_o      (ir_we_o),
    .pc_we_o      (pc_we_o),
    .pc_src_o     (pc_src_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .shamt_o      (shamt_o),
    .reg_we_o     (reg_we_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .illegal_o    (illegal_o),
    .bus_err_o    (bus_err_o)
  );

  // Each task starts just after a falling edge with the DUT in FETCH.
  task automatic test_reset();
    rst_i = 1'b0; mem_ack_i = 1'b1; zero_i = 1'b1; instr_i = I_ADD;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({mem_rd_o, mem_wr_o, iord_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o,
         reg_dst_o, mem_to_reg_o, illegal_o, bus_err_o} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000000", {mem_rd_o, mem_wr_o,
               iord_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o, reg_dst_o,
               mem_to_reg_o, illegal_o, bus_err_o});
    end
    checks++;
    if ({alu_ctrl_o, alu_src_a_o, alu_src_b_o, shamt_o} !== 12'b0) begin
      errors++;
      $display("FAIL reset_alu: got %h want 000", {alu_ctrl_o, alu_src_a_o, alu_src_b_o, shamt_o});
    end
    mem_ack_i = 1'b0; zero_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (mem_rd_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: mem_rd_o=%b want 0", mem_rd_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({mem_rd_o, alu_src_b_o, iord_o} !== 4'b1010) begin
      errors++; $display("FAIL reset_fetch: {rd,srcb,iord}=%b want 1010", {mem_rd_o, alu_src_b_o, iord_o});
    end
  endtask

  task automatic test_add();
    int pcw;
    pcw = 0;
    instr_i = I_ADD; mem_ack_i = 1'b1;
    #1;
    checks++;
    if ({mem_rd_o, ir_we_o, pc_we_o, pc_src_o, iord_o} !== 5'b11100) begin
      errors++; $display("FAIL add_fetch: got %b want 11100", {mem_rd_o, ir_we_o, pc_we_o, pc_src_o, iord_o});
    end
    if (pc_we_o === 1'b1) pcw++;
    @(negedge clk_i);
    #1;  // ack still high in DECODE: must be ignored
    checks++;
    if ({alu_src_b_o, alu_ctrl_o, ir_we_o, mem_rd_o} !== 8'b11000000) begin
      errors++; $display("FAIL add_decode: got %b want 11000000", {alu_src_b_o, alu_ctrl_o, ir_we_o, mem_rd_o});
    end
    if (pc_we_o === 1'b1) pcw++;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({alu_ctrl_o, alu_src_a_o, alu_src_b_o, reg_we_o} !== 8'b00001000) begin
      errors++; $display("FAIL add_exec: got %b want 00001000", {alu_ctrl_o, alu_src_a_o, alu_src_b_o, reg_we_o});
    end
    if (pc_we_o === 1'b1) pcw++;
    @(negedge clk_i);
    #1;
    checks++;
    if ({reg_we_o, reg_dst_o, mem_to_reg_o} !== 3'b110) begin
      errors++; $display("FAIL add_wb: got %b want 110", {reg_we_o, reg_dst_o, mem_to_reg_o});
    end
    if (pc_we_o === 1'b1) pcw++;
    checks++;
    if (pcw != 1) begin
      errors++; $display("FAIL add_pc_we_count: got %0d want 1", pcw);
    end
    @(negedge clk_i);
  endtask

  task automatic test_branch(input logic [31:0] ins, input logic z,
                             input logic [3:0] exp_op);
    instr_i = ins; mem_ack_i = 1'b1;
    #1;
    checks++;
    if (ir_we_o !== 1'b1) begin
      errors++; $display("FAIL br_fetch: ir_we_o=%b want 1", ir_we_o);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({alu_src_b_o, pc_we_o} !== 3'b110) begin
      errors++; $display("FAIL br_decode: got %b want 110", {alu_src_b_o, pc_we_o});
    end
    @(negedge clk_i);
    zero_i = z;
    #1;
    checks++;
    if ({alu_ctrl_o, pc_src_o, pc_we_o, alu_src_a_o, alu_src_b_o} !== {exp_op, 1'b1, z, 1'b1, 2'b00}) begin
      errors++; $display("FAIL br_cmp: got %b want %b", {alu_ctrl_o, pc_src_o, pc_we_o, alu_src_a_o, alu_src_b_o},
                         {exp_op, 1'b1, z, 1'b1, 2'b00});
    end
    @(negedge clk_i);
    zero_i = 1'b0;
  endtask

  task automatic test_lw_delayed();
    int rd_n, wb_cyc;
    logic m2r, dst;
    rd_n = 0; wb_cyc = 0; m2r = 1'b0; dst = 1'b1;
    instr_i = I_LW;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      mem_ack_i = (cyc == 1) || (cyc == 7);
      #1;
      if (cyc == 3) begin
        checks++;
        if ({alu_src_b_o, alu_src_a_o} !== 3'b101) begin
          errors++; $display("FAIL lw_exec: got %b want 101", {alu_src_b_o, alu_src_a_o});
        end
      end
      if (iord_o === 1'b1 && mem_rd_o === 1'b1) rd_n++;
      if (reg_we_o === 1'b1) begin
        wb_cyc = cyc; m2r = mem_to_reg_o; dst = reg_dst_o;
      end
      @(negedge clk_i);
      if (wb_cyc != 0) break;
    end
    mem_ack_i = 1'b0;
    checks++;
    if (rd_n != 4) begin
      errors++; $display("FAIL lw_rd_held: got %0d cycles want 4", rd_n);
    end
    checks++;
    if (wb_cyc != 8) begin
      errors++; $display("FAIL lw_latency: WB in cycle %0d want 8", wb_cyc);
    end
    checks++;
    if ({m2r, dst} !== 2'b10) begin
      errors++; $display("FAIL lw_wb: {m2r,dst}=%b want 10", {m2r, dst});
    end
  endtask

  task automatic test_sll_illegal();
    instr_i = I_SLL; mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if (shamt_o !== 5'd0) begin
      errors++; $display("FAIL sll_decode_shamt: got %0d want 0", shamt_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({alu_ctrl_o, shamt_o, alu_src_b_o} !== {4'd6, 5'd5, 2'd0}) begin
      errors++; $display("FAIL sll_exec: op=%0d shamt=%0d srcb=%0d want 6 5 0", alu_ctrl_o, shamt_o, alu_src_b_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({reg_we_o, reg_dst_o} !== 2'b11) begin
      errors++; $display("FAIL sll_wb: got %b want 11", {reg_we_o, reg_dst_o});
    end
    @(negedge clk_i);
    instr_i = I_BADO; mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if (illegal_o !== 1'b1) begin
      errors++; $display("FAIL illegal_op: illegal_o=%b want 1", illegal_o);
    end
    @(negedge clk_i);
    instr_i = I_BADF; mem_ack_i = 1'b1;
    #1;
    checks++;
    if ({mem_rd_o, illegal_o, ir_we_o} !== 3'b101) begin
      errors++; $display("FAIL illegal_next_fetch: got %b want 101", {mem_rd_o, illegal_o, ir_we_o});
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if (illegal_o !== 1'b1) begin
      errors++; $display("FAIL illegal_funct: illegal_o=%b want 1", illegal_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    mem_ack_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if ({mem_rd_o, bus_err_o} !== 2'b10) begin
        errors++; $display("FAIL tmo_wait_%0d: {rd,err}=%b want 10", c, {mem_rd_o, bus_err_o});
      end
      @(negedge clk_i);
    end
    #1;
    checks++;
    if ({mem_rd_o, bus_err_o, ir_we_o} !== 3'b010) begin
      errors++; $display("FAIL tmo_fetch_err: {rd,err,irwe}=%b want 010", {mem_rd_o, bus_err_o, ir_we_o});
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({mem_rd_o, bus_err_o} !== 2'b10) begin
      errors++; $display("FAIL tmo_retry: {rd,err}=%b want 10", {mem_rd_o, bus_err_o});
    end
    repeat (3) @(negedge clk_i);
    instr_i = I_ADD; mem_ack_i = 1'b1;
    #1;
    checks++;
    if ({ir_we_o, bus_err_o} !== 2'b10) begin
      errors++; $display("FAIL tmo_ack_wins: {irwe,err}=%b want 10", {ir_we_o, bus_err_o});
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({bus_err_o, alu_src_b_o} !== 3'b011) begin
      errors++; $display("FAIL tmo_after_ack: {err,srcb}=%b want 011", {bus_err_o, alu_src_b_o});
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    instr_i = I_SW; mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    #1;
    checks++;
    if ({alu_ctrl_o, alu_src_b_o} !== 6'b000010) begin
      errors++; $display("FAIL sw_exec: got %b want 000010", {alu_ctrl_o, alu_src_b_o});
    end
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    #1;
    checks++;
    if ({mem_wr_o, iord_o, reg_we_o, mem_rd_o} !== 4'b1100) begin
      errors++; $display("FAIL sw_memwr: got %b want 1100", {mem_wr_o, iord_o, reg_we_o, mem_rd_o});
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({mem_rd_o, ir_we_o, mem_wr_o} !== 3'b110) begin
      errors++; $display("FAIL b2b_fetch: got %b want 110", {mem_rd_o, ir_we_o, mem_wr_o});
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if ({mem_wr_o, bus_err_o} !== 2'b10) begin
        errors++; $display("FAIL sw_wait_%0d: {wr,err}=%b want 10", c, {mem_wr_o, bus_err_o});
      end
      @(negedge clk_i);
    end
    #1;
    checks++;
    if ({mem_wr_o, bus_err_o} !== 2'b01) begin
      errors++; $display("FAIL sw_tmo: {wr,err}=%b want 01", {mem_wr_o, bus_err_o});
    end
    @(negedge clk_i);
    #1;
    checks++;
    if ({mem_rd_o, reg_we_o, bus_err_o, iord_o} !== 4'b1000) begin
      errors++; $display("FAIL sw_abandon: got %b want 1000", {mem_rd_o, reg_we_o, bus_err_o, iord_o});
    end
  endtask

  task automatic test_reset_mid_wb();
    instr_i = I_ADD; mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (reg_we_o !== 1'b1) begin
      errors++; $display("FAIL rst_wb_pre: reg_we_o=%b want 1", reg_we_o);
    end
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({reg_we_o, reg_dst_o, mem_rd_o} !== 3'b000) begin
      errors++; $display("FAIL rst_async_drop: got %b want 000", {reg_we_o, reg_dst_o, mem_rd_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({mem_rd_o, reg_we_o} !== 2'b00) begin
      errors++; $display("FAIL rst_idle: got %b want 00", {mem_rd_o, reg_we_o});
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (mem_rd_o !== 1'b1) begin
      errors++; $display("FAIL rst_then_fetch: mem_rd_o=%b want 1", mem_rd_o);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch(I_BEQ, 1'b1, 4'd9);
    test_branch(I_BEQ, 1'b0, 4'd9);
    test_branch(I_BNE, 1'b1, 4'd10);
    test_lw_delayed();
    test_sll_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
